pipe_bubble_ctrl: RTL

- Hazard sequencer for the 16-bit pipelined CPU.
- Decides each cycle whether the PC and IF/ID register advance, and drives the 1-bit gate inputs of the 16-bit AND-masking stages. Gate=0 zeroes an instruction word into a NOP bubble.
- Handles three cases: load-use stalls, taken-branch flushes lasting FLUSH_CYCLES, and memory-wait freezes.

---
 rtl/pipe_bubble_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pipe_bubble_ctrl.sv
// pipe_bubble_ctrl
// Hazard sequencer for the 16-bit pipelined CPU. Every cycle it decides
// whether the PC and the IF/ID register advance. It also drives the 1-bit
// gates of the AND-masking stages; a gate of 0 turns the word into a NOP
// bubble. It handles load-use stalls, taken-branch flushes and
// memory-wait freezes.
//
// Ports:
//   clk          rising-edge system clock
//   rst_n        asynchronous active-low reset
//   id_instr     instruction in ID (rd[11:9], rs[8:6], rt[5:3])
//   id_uses_rt   ID instruction reads rt
//   ex_mem_read  EX-stage instruction is a load
//   ex_rd        EX-stage destination register
//   branch_taken branch resolved taken in EX (single-cycle pulse)
//   mem_wait     data memory not ready
//   pc_we        PC write enable
//   ifid_we      IF/ID register write enable
//   ifid_gate    AND-mask gate on the IF/ID input word
//   idex_gate    AND-mask gate on the ID/EX control/instruction word
//   busy         sequencer is in any state other than RUN
//
// Optional feature (macro PIPE_BUBBLE_STATS_EN):
//   stats_clr    synchronous clear of stall_count
//   stall_count  saturating count of cycles with pc_we=0 or ifid_gate=0

module pipe_bubble_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int RD_W         = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     id_instr,
  input  logic            id_uses_rt,
  input  logic            ex_mem_read,
  input  logic [RD_W-1:0] ex_rd,
  input  logic            branch_taken,
  input  logic            mem_wait,
  output logic            pc_we,
  output logic            ifid_we,
  output logic            ifid_gate,
  output logic            idex_gate,
  output logic            busy
`ifdef PIPE_BUBBLE_STATS_EN
  ,
  input  logic            stats_clr,
  output logic [15:0]     stall_count
`endif
);

  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH, FREEZE} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] flush_cnt, flush_cnt_nxt;
  logic       out_en;
  logic       lu;
  logic       pc_we_raw, ifid_we_raw, ifid_gate_raw, idex_gate_raw;
  logic       unused_bits;

  assign unused_bits = ^id_instr[15:9];

  // Load-use hit: a load in EX writes a register that the ID instruction
  // reads. Register 0 is hardwired, so it never causes a stall.
  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((ex_rd == RD_W'(id_instr[8:6])) ||
               (id_uses_rt && (ex_rd == RD_W'(id_instr[5:3]))));

  // State and flush counter. out_en is cleared by reset and set on the
  // first edge after release. This holds all outputs at 0 until the
  // sequencer has actually been clocked out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= 3'd0;
      out_en    <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      out_en    <= 1'b1;
    end
  end

  // Mealy next-state and output logic. Priority is branch > mem_wait > lu.
  // The flush counter holds the number of FLUSH cycles still to come.
  // Reaching one therefore means this is the last bubble cycle.
  // On release from FREEZE, a pending load-use is handled in the same cycle.
  // Branches are ignored during FREEZE because EX is held.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    pc_we_raw     = 1'b1;
    ifid_we_raw   = 1'b1;
    ifid_gate_raw = 1'b1;
    idex_gate_raw = 1'b1;
    case (state)
      RUN, LU_STALL: begin
        if (branch_taken) begin
          ifid_gate_raw = 1'b0;
          idex_gate_raw = 1'b0;
          flush_cnt_nxt = FLUSH_LOAD;
          state_nxt     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (mem_wait) begin
          pc_we_raw   = 1'b0;
          ifid_we_raw = 1'b0;
          state_nxt   = FREEZE;
        end else if (lu) begin
          pc_we_raw     = 1'b0;
          ifid_we_raw   = 1'b0;
          idex_gate_raw = 1'b0;
          state_nxt     = LU_STALL;
        end else begin
          state_nxt = RUN;
        end
      end
      FLUSH: begin
        ifid_gate_raw = 1'b0;
        idex_gate_raw = 1'b0;
        if (branch_taken) begin
          flush_cnt_nxt = FLUSH_LOAD;
          state_nxt     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (flush_cnt <= 3'd1) begin
          flush_cnt_nxt = 3'd0;
          state_nxt     = RUN;
        end else begin
          flush_cnt_nxt = flush_cnt - 3'd1;
        end
      end
      FREEZE: begin
        if (mem_wait) begin
          pc_we_raw   = 1'b0;
          ifid_we_raw = 1'b0;
        end else if (lu) begin
          pc_we_raw     = 1'b0;
          ifid_we_raw   = 1'b0;
          idex_gate_raw = 1'b0;
          state_nxt     = LU_STALL;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt     = RUN;
        flush_cnt_nxt = 3'd0;
      end
    endcase
  end

  // All outputs are forced low while in reset and until the first edge.
  assign pc_we     = out_en & pc_we_raw;
  assign ifid_we   = out_en & ifid_we_raw;
  assign ifid_gate = out_en & ifid_gate_raw;
  assign idex_gate = out_en & idex_gate_raw;
  assign busy      = out_en & (state != RUN);

`ifdef PIPE_BUBBLE_STATS_EN
  // Saturating stall/bubble cycle counter. A clear takes precedence over
  // an increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= 16'd0;
    end else if (stats_clr) begin
      stall_count <= 16'd0;
    end else if ((!pc_we || !ifid_gate) && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
